// File: rtl/auth_msg_transmitter.sv
// Buffers one authentication request (header + payload) taken over a four-phase
// req/ack handshake and serializes it byte by byte under valid/ready flow control.
module auth_msg_transmitter #(
    parameter int HEADER_BYTES  = 4,
    parameter int PAYLOAD_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       msg_req,
    input  logic [HEADER_BYTES*8-1:0]  header,
    input  logic [PAYLOAD_BYTES*8-1:0] payload,
    output logic                       msg_ack,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       tx_last,
    output logic                       busy,
    output logic                       tx_done
);

    localparam int MSG_BYTES = HEADER_BYTES + PAYLOAD_BYTES;
    localparam int IDX_W     = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

    typedef enum logic [1:0] {IDLE, HANDSHAKE, SEND, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d, idx_inc;
    logic [7:0]              buf_q [MSG_BYTES];
    logic [MSG_BYTES*8-1:0]  msg_w;
    logic                    load;
    logic                    ack_d, valid_d, last_d, done_d;
    logic [7:0]              data_d;

    assign msg_w   = {payload, header};
    assign idx_inc = idx_q + IDX_W'(1);
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ack_d   = msg_ack;
        valid_d = tx_valid;
        last_d  = tx_last;
        done_d  = 1'b0;
        data_d  = tx_data;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (msg_req) begin
                    load    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = HANDSHAKE;
                end
            end
            HANDSHAKE: begin
                if (!msg_req) begin
                    ack_d   = 1'b0;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    data_d  = buf_q[0];
                    last_d  = (MSG_BYTES == 1);
                    state_d = SEND;
                end
            end
            SEND: begin
                // Index, data and last only move on an accepted byte, so a stall holds them.
                if (tx_valid && tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = buf_q[idx_inc];
                        last_d = (idx_inc == LAST_IDX);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            msg_ack  <= 1'b0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            tx_done  <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            msg_ack  <= ack_d;
            tx_valid <= valid_d;
            tx_last  <= last_d;
            tx_done  <= done_d;
            tx_data  <= data_d;
        end
    end

    // Message buffer is pure data: no reset, written only on capture.
    always_ff @(posedge clk) begin
        if (load && !reset) begin
            for (int i = 0; i < MSG_BYTES; i++) begin
                buf_q[i] <= msg_w[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/auth_msg_transmitter.md
# auth_msg_transmitter

Serializes one authentication request message (header + payload, e.g. a GET_CERTIFICATE request) into a byte stream toward the USB Type-C transport. It sits directly downstream of the certificate control stage. It consumes that stage's header/payload buses under a four-phase request/acknowledge handshake: its Ack_out drives msg_req, and msg_ack drives its Ack_in. It then emits the message bytes with valid/ready flow control. Only one message is buffered; a new request is not acknowledged until the previous message is fully sent.

## Interface
- HEADER_BYTES, 4, header length in bytes
- PAYLOAD_BYTES, 4, payload length in bytes
- MSG_BYTES, HEADER_BYTES+PAYLOAD_BYTES, total bytes per message (derived, not overridden)
- clk  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- msg_req  input  1  request from upstream; header/payload valid while high
- header  input  HEADER_BYTES*8  message header, byte 0 = bits [7:0]
- payload  input  PAYLOAD_BYTES*8  message payload, byte 0 = bits [7:0]
- msg_ack  output  1  acknowledge to upstream (four-phase)
- tx_data  output  8  current byte
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  downstream accepts byte when tx_valid & tx_ready
- tx_last  output  1  high with the final byte of a message
- busy  output  1  high whenever state != IDLE
- tx_done  output  1  one-cycle pulse after the final byte is accepted

## Operation
- Registered FSM with states IDLE, HANDSHAKE, SEND and DONE. All outputs are registered or decoded from registered state and counters only.
- Reset: state IDLE; msg_ack, tx_valid, tx_last, tx_done and busy are 0; tx_data is 0x00; byte index is 0. Buffer contents are don't-care.
- IDLE:
  - On a posedge sampling msg_req=1, load buffer = {payload, header} and set msg_ack=1.
  - Go to HANDSHAKE.
  - Capture is level-based. msg_req is assumed to stay high until msg_ack is seen.
- HANDSHAKE:
  - Hold msg_ack=1 until a posedge samples msg_req=0.
  - Then set msg_ack=0, byte index=0, tx_valid=1 and tx_data=buffer byte 0.
  - Go to SEND.
  - Header/payload changes after capture have no effect.
- SEND:
  - tx_data = buffer byte[index]. Transmit order is header byte 0..HEADER_BYTES-1, then payload byte 0..PAYLOAD_BYTES-1.
  - tx_last = (index == MSG_BYTES-1).
  - On tx_valid & tx_ready, increment index. If the accepted byte was the last one, clear tx_valid/tx_last and go to DONE.
  - When tx_ready=0, hold tx_data, tx_valid, tx_last and index stable.
- DONE: tx_done=1 for exactly one cycle, then IDLE.
- msg_req high while the FSM is in SEND or DONE is not acknowledged. It is captured on the first IDLE cycle, which gives natural backpressure to upstream. No error is raised.
- The byte index is $clog2(MSG_BYTES) bits wide (minimum 1). It never exceeds MSG_BYTES-1 and does not wrap within a message.
- Reset mid-operation: state returns to IDLE and all outputs return to their reset values on that edge. A partially sent message is discarded and not resumed. msg_ack drops even if msg_req is still high; if msg_req is still high after reset is released, it is captured as a fresh request.

## Timing
- Edge k samples msg_req=1 in IDLE: msg_ack=1 and busy=1 from edge k.
- Edge m (m>k) samples msg_req=0: msg_ack=0, tx_valid=1 and tx_data=byte 0 from edge m.
- With tx_ready held 1: byte i is presented during cycle m+i. The last byte is presented in cycle m+MSG_BYTES-1 with tx_last=1.
- tx_done is high in cycle m+MSG_BYTES. busy=0 and IDLE from edge m+MSG_BYTES+1.
- Each cycle of tx_ready=0 in SEND adds exactly one cycle.
- Minimum request-to-next-capture: MSG_BYTES+3 cycles after msg_req falls (default 11).
- tx_valid, once asserted, stays high until its byte is accepted. It is only dropped by reset.

## Test plan
- Reset values: assert reset 3 cycles with msg_req=1 -> msg_ack, tx_valid, tx_last, tx_done and busy are 0; tx_data is 0x00. After release, the next edge captures and msg_ack=1.
- Basic GET_CERTIFICATE: header=32'h0000_8101, payload=32'h0200_0000, tx_ready=1, msg_req dropped 2 cycles after msg_ack -> bytes 01 81 00 00 00 00 00 02 on consecutive cycles, tx_last only on 0x02, tx_done one cycle later, busy then 0.
- Backpressure: same message with tx_ready toggling 1,0,0,1,… -> no byte duplicated or dropped, data/last stable while stalled, total SEND cycles = 8 + stall cycles.
- Input isolation: change header/payload to 0xFFFFFFFF right after msg_ack rises -> the transmitted stream still equals the captured values.
- Back-to-back: raise msg_req again during SEND -> msg_ack stays 0 until 1 cycle after tx_done, then rises. The second message follows with no interleaving.
- Reset mid-send: assert reset after 3 bytes accepted -> next edge has tx_valid=0 and busy=0. A following request transmits all 8 bytes from byte 0.
